// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory req/ack fetch port
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner feeding IF/ID, with stall pending buffer and redirect drain
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_id_write,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  fetch_stage_if.master imem,
  output logic          fetch_valid,
  output logic [31:0]   fetch_pc,
  output logic [31:0]   fetch_instr
);
  typedef enum logic [1:0] {REQ, HOLD, DRAIN} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, drain_q, drain_d;
  logic [31:0] slot_pc_q, slot_pc_d, slot_instr_q, slot_instr_d;
  logic [31:0] pend_pc_q, pend_pc_d, pend_instr_q, pend_instr_d;
  logic        valid_q, valid_d;
  logic        ack, slot_free;
  assign imem.imem_req  = (state_q != HOLD) && !reset;
  assign imem.imem_addr = (state_q == DRAIN) ? drain_q : pc_q;
  assign ack            = imem.imem_req && imem.imem_ack;
  assign slot_free      = !valid_q || if_id_write;
  assign fetch_valid    = valid_q;
  assign fetch_pc       = slot_pc_q;
  assign fetch_instr    = valid_q ? slot_instr_q : NOP_INSTR;
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_d      = drain_q;
    slot_pc_d    = slot_pc_q;
    slot_instr_d = slot_instr_q;
    pend_pc_d    = pend_pc_q;
    pend_instr_d = pend_instr_q;
    valid_d      = valid_q;
    if (redirect) begin
      // an unacked request must still complete, so remember its address
      pc_d         = redirect_pc & 32'hFFFF_FFFC;
      valid_d      = 1'b0;
      pend_pc_d    = '0;
      pend_instr_d = '0;
      state_d      = (imem.imem_req && !imem.imem_ack) ? DRAIN : REQ;
      drain_d      = (state_q == DRAIN) ? drain_q : pc_q;
    end else begin
      case (state_q)
        REQ: begin
          if (ack) begin
            pc_d = pc_q + 32'd4;
            if (slot_free) begin
              slot_pc_d    = pc_q;
              slot_instr_d = imem.imem_rdata;
              valid_d      = 1'b1;
            end else begin
              pend_pc_d    = pc_q;
              pend_instr_d = imem.imem_rdata;
              state_d      = HOLD;
            end
          end else if (if_id_write) begin
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (if_id_write) begin
            slot_pc_d    = pend_pc_q;
            slot_instr_d = pend_instr_q;
            state_d      = REQ;
          end
        end
        DRAIN:   state_d = ack ? REQ : DRAIN;
        default: state_d = REQ;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      drain_q      <= '0;
      slot_pc_q    <= '0;
      slot_instr_q <= NOP_INSTR;
      pend_pc_q    <= '0;
      pend_instr_q <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_q      <= drain_d;
      slot_pc_q    <= slot_pc_d;
      slot_instr_q <= slot_instr_d;
      pend_pc_q    <= pend_pc_d;
      pend_instr_q <= pend_instr_d;
      valid_q      <= valid_d;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage with a variable-latency memory model
module tb_fetch_stage;
  logic clock, reset, iw, redirect, rst_b, iw_b;
  logic [31:0] rpc;
  logic        va, vb;
  logic [31:0] pa, ia, pb, ib;
  int unsigned wait_n, cnt;
  int n_chk = 0, n_fail = 0;
  fetch_stage_if a_if ();
  fetch_stage_if b_if ();
  fetch_stage dut_a (
    .clock(clock), .reset(reset), .if_id_write(iw), .redirect(redirect), .redirect_pc(rpc),
    .imem(a_if), .fetch_valid(va), .fetch_pc(pa), .fetch_instr(ia));
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clock(clock), .reset(rst_b), .if_id_write(iw_b), .redirect(1'b0), .redirect_pc(32'h0),
    .imem(b_if), .fetch_valid(vb), .fetch_pc(pb), .fetch_instr(ib));
  assign a_if.imem_ack   = a_if.imem_req && (cnt >= wait_n);
  assign a_if.imem_rdata = a_if.imem_addr ^ 32'hA5A5_0000;
  assign b_if.imem_ack   = b_if.imem_req;
  assign b_if.imem_rdata = b_if.imem_addr ^ 32'hA5A5_0000;
  always @(posedge clock)
    if (reset || (a_if.imem_req && a_if.imem_ack)) cnt <= 0;
    else if (a_if.imem_req) cnt <= cnt + 1;
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic nxt();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1; rst_b = 1; iw = 1; iw_b = 1; redirect = 0; rpc = '0; wait_n = 0;
    nxt(); nxt(); #1;
    chk("rst_valid", va, 1'b0);
    chk("rst_pc", pa, 32'h0);
    chk("rst_instr", ia, 32'h13);
    chk("rst_req", a_if.imem_req, 1'b0);
    chk("rst_addr", a_if.imem_addr, 32'h0);
    nxt(); reset = 0; #1;
    chk("c0_req", a_if.imem_req, 1'b1);
    chk("c0_addr", a_if.imem_addr, 32'h0);
    chk("c0_valid", va, 1'b0);
    nxt(); #1;
    chk("c1_addr", a_if.imem_addr, 32'h4);
    chk("c1_valid", va, 1'b1);
    chk("c1_pc", pa, 32'h0);
    chk("c1_instr", ia, 32'hA5A5_0000);
    nxt(); #1;
    chk("c2_addr", a_if.imem_addr, 32'h8);
    chk("c2_pc", pa, 32'h4);
    chk("c2_instr", ia, 32'hA5A5_0004);
    nxt(); iw = 0; #1;
    chk("c3_req", a_if.imem_req, 1'b1);
    chk("c3_addr", a_if.imem_addr, 32'hC);
    chk("c3_pc", pa, 32'h8);
    nxt(); #1;
    chk("stall1_req", a_if.imem_req, 1'b0);
    chk("stall1_pc", pa, 32'h8);
    chk("stall1_valid", va, 1'b1);
    nxt(); #1;
    chk("stall2_req", a_if.imem_req, 1'b0);
    nxt(); #1;
    chk("stall3_req", a_if.imem_req, 1'b0);
    chk("stall3_pc", pa, 32'h8);
    nxt(); iw = 1; #1;
    chk("release_req", a_if.imem_req, 1'b0);
    chk("release_pc", pa, 32'h8);
    nxt(); #1;
    chk("pend_pc", pa, 32'hC);
    chk("pend_instr", ia, 32'hA5A5_000C);
    chk("pend_req", a_if.imem_req, 1'b1);
    chk("pend_addr", a_if.imem_addr, 32'h10);
    nxt(); redirect = 1; rpc = 32'h0000_0102; #1;
    chk("redir_pc_hold", pa, 32'h10);
    chk("redir_valid_hold", va, 1'b1);
    chk("redir_addr", a_if.imem_addr, 32'h14);
    nxt(); redirect = 0; #1;
    chk("newpath_addr", a_if.imem_addr, 32'h100);
    chk("newpath_valid", va, 1'b0);
    chk("newpath_instr", ia, 32'h13);
    nxt(); wait_n = 2; #1;
    chk("newpath_slot_pc", pa, 32'h100);
    chk("newpath_slot_instr", ia, 32'hA5A5_0100);
    chk("slow1_addr", a_if.imem_addr, 32'h104);
    nxt(); #1;
    chk("slow2_req", a_if.imem_req, 1'b1);
    chk("slow2_addr", a_if.imem_addr, 32'h104);
    chk("slow2_valid", va, 1'b0);
    chk("slow2_instr", ia, 32'h13);
    nxt(); #1;
    chk("slow3_addr", a_if.imem_addr, 32'h104);
    chk("slow3_valid", va, 1'b0);
    nxt(); wait_n = 3; #1;
    chk("slow_slot_valid", va, 1'b1);
    chk("slow_slot_pc", pa, 32'h104);
    chk("slow_slot_instr", ia, 32'hA5A5_0104);
    chk("slow_next_addr", a_if.imem_addr, 32'h108);
    nxt(); redirect = 1; rpc = 32'h200; #1;
    chk("drain_in_valid", va, 1'b0);
    chk("drain_in_addr", a_if.imem_addr, 32'h108);
    nxt(); rpc = 32'h300; #1;
    chk("drain1_req", a_if.imem_req, 1'b1);
    chk("drain1_addr", a_if.imem_addr, 32'h108);
    chk("drain1_valid", va, 1'b0);
    nxt(); redirect = 0; wait_n = 0; #1;
    chk("drain2_addr", a_if.imem_addr, 32'h108);
    chk("drain2_valid", va, 1'b0);
    nxt(); #1;
    chk("after_drain_addr", a_if.imem_addr, 32'h300);
    chk("after_drain_req", a_if.imem_req, 1'b1);
    chk("after_drain_valid", va, 1'b0);
    nxt(); #1;
    chk("p300_valid", va, 1'b1);
    chk("p300_pc", pa, 32'h300);
    chk("p300_instr", ia, 32'hA5A5_0300);
    nxt(); rst_b = 0; #1;
    chk("b0_req", b_if.imem_req, 1'b1);
    chk("b0_addr", b_if.imem_addr, 32'hFFFF_FFFC);
    chk("b0_valid", vb, 1'b0);
    nxt(); iw_b = 0; #1;
    chk("b1_wrap_addr", b_if.imem_addr, 32'h0);
    chk("b1_pc", pb, 32'hFFFF_FFFC);
    chk("b1_instr", ib, 32'h5A5A_FFFC);
    nxt(); rst_b = 1; #1;
    chk("b2_req", b_if.imem_req, 1'b0);
    chk("b2_pc", pb, 32'hFFFF_FFFC);
    chk("b2_valid", vb, 1'b1);
    nxt(); #1;
    chk("b3_valid", vb, 1'b0);
    chk("b3_pc", pb, 32'h0);
    chk("b3_instr", ib, 32'h13);
    chk("b3_req", b_if.imem_req, 1'b0);
    chk("b3_addr", b_if.imem_addr, 32'hFFFF_FFFC);
    nxt(); rst_b = 0; iw_b = 1; #1;
    chk("b4_req", b_if.imem_req, 1'b1);
    chk("b4_addr", b_if.imem_addr, 32'hFFFF_FFFC);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
